// File: rtl/tile_scroll_mapper_if.sv
// Pixel-position, tile-ROM, palette and colour signals of the background tile mapper.
interface tile_scroll_mapper_if #(
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned SCROLL_W = 7
);
  logic [9:0]          DrawX;
  logic [9:0]          DrawY;
  logic                blank;
  logic [SCROLL_W-1:0] scroll_x;
  logic [ADDR_W-1:0]   rom_addr;
  logic [IDX_W-1:0]    rom_q;
  logic [IDX_W-1:0]    pal_index;
  logic [3:0]          pal_red;
  logic [3:0]          pal_green;
  logic [3:0]          pal_blue;
  logic [3:0]          red;
  logic [3:0]          green;
  logic [3:0]          blue;
  logic                opaque;

  modport slave (
    input  DrawX, DrawY, blank, scroll_x, rom_q, pal_red, pal_green, pal_blue,
    output rom_addr, pal_index, red, green, blue, opaque
  );

  modport master (
    output DrawX, DrawY, blank, scroll_x, rom_q, pal_red, pal_green, pal_blue,
    input  rom_addr, pal_index, red, green, blue, opaque
  );
endinterface

// File: rtl/tile_scroll_mapper.sv
// Scaled, repeated, horizontally scrolled background tile mapper driven by
// incremental texel counters; colour is gated by a ROM-latency-matched blank.
module tile_scroll_mapper #(
  parameter int unsigned TILE_W          = 96,
  parameter int unsigned TILE_H          = 96,
  parameter int unsigned SCALE           = 5,
  parameter int unsigned IDX_W           = 3,
  parameter int unsigned ROM_LATENCY     = 1,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned ADDR_W          = $clog2(TILE_W * TILE_H)
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  tile_scroll_mapper_if.slave  bus
);

  localparam int unsigned TX_W = $clog2(TILE_W);
  localparam int unsigned TY_W = $clog2(TILE_H);
  localparam int unsigned SX_W = 3;
  localparam int unsigned BL_N = ROM_LATENCY + 1;

  localparam logic [TX_W-1:0]  TX_MAX = TX_W'(TILE_W - 1);
  localparam logic [TY_W-1:0]  TY_MAX = TY_W'(TILE_H - 1);
  localparam logic [SX_W-1:0]  S_MAX  = SX_W'(SCALE - 1);
  localparam logic [IDX_W-1:0] T_IDX  = IDX_W'(TRANSPARENT_IDX);

  logic [9:0]        prev_x_q, prev_y_q;
  logic [TX_W-1:0]   shadow_q, shadow_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [TY_W-1:0]   ty_q, ty_d;
  logic [SX_W-1:0]   sx_q, sx_d;
  logic [SX_W-1:0]   sy_q, sy_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [BL_N-1:0]   blank_dly_q, blank_dly_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              opaque_q, opaque_d;

  logic frame_start, line_start, x_step, y_step, col_zero;

  // Position change detection against the previous sample.
  assign frame_start = (bus.DrawX == '0) && (bus.DrawY == '0) &&
                       !((prev_x_q == '0) && (prev_y_q == '0));
  assign line_start  = (bus.DrawX == '0) && (prev_x_q != '0);
  assign x_step      = (bus.DrawX != prev_x_q) && (bus.DrawX != '0);
  assign y_step      = (bus.DrawY != prev_y_q) && (bus.DrawY != '0);
  assign col_zero    = (bus.DrawY == '0) && (prev_y_q != '0);

  always_comb begin
    shadow_d = shadow_q;
    tx_d     = tx_q;
    sx_d     = sx_q;
    ty_d     = ty_q;
    sy_d     = sy_q;

    if (frame_start) begin
      shadow_d = (32'(bus.scroll_x) < TILE_W) ? bus.scroll_x
                                              : bus.scroll_x - TX_W'(TILE_W);
    end

    // A frame start also restarts the line so the new scroll takes effect at once.
    if (line_start || frame_start) begin
      tx_d = shadow_d;
      sx_d = '0;
    end else if (x_step) begin
      if (sx_q == S_MAX) begin
        sx_d = '0;
        tx_d = (tx_q == TX_MAX) ? '0 : tx_q + TX_W'(1);
      end else begin
        sx_d = sx_q + SX_W'(1);
      end
    end

    if (col_zero) begin
      ty_d = '0;
      sy_d = '0;
    end else if (y_step) begin
      if (sy_q == S_MAX) begin
        sy_d = '0;
        ty_d = (ty_q == TY_MAX) ? '0 : ty_q + TY_W'(1);
      end else begin
        sy_d = sy_q + SX_W'(1);
      end
    end

    rom_addr_d = ADDR_W'(ty_d) * ADDR_W'(TILE_W) + ADDR_W'(tx_d);
  end

  // Blank delay matches the address register plus ROM latency.
  always_comb begin
    blank_dly_d = {blank_dly_q[BL_N-2:0], bus.blank};
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    opaque_d    = 1'b0;
    if (blank_dly_q[BL_N-1] && (bus.rom_q != T_IDX)) begin
      red_d    = bus.pal_red;
      green_d  = bus.pal_green;
      blue_d   = bus.pal_blue;
      opaque_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_x_q    <= '1;
      prev_y_q    <= '1;
      shadow_q    <= '0;
      tx_q        <= '0;
      sx_q        <= '0;
      ty_q        <= '0;
      sy_q        <= '0;
      rom_addr_q  <= '0;
      blank_dly_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      opaque_q    <= 1'b0;
    end else begin
      prev_x_q    <= bus.DrawX;
      prev_y_q    <= bus.DrawY;
      shadow_q    <= shadow_d;
      tx_q        <= tx_d;
      sx_q        <= sx_d;
      ty_q        <= ty_d;
      sy_q        <= sy_d;
      rom_addr_q  <= rom_addr_d;
      blank_dly_q <= blank_dly_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      opaque_q    <= opaque_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pal_index = bus.rom_q;
  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
  assign bus.opaque    = opaque_q;

endmodule

// File: tb/tb_tile_scroll_mapper.sv
// Directed bench: SCALE=1/ROM_LATENCY=1 instance for addressing and scroll,
// SCALE=5/ROM_LATENCY=2 instance with a ROM and palette model for colour path.
module tb_tile_scroll_mapper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] dx = '0;
  logic [9:0] dy = '0;
  logic       blk = 1'b0;
  logic [6:0] scr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tile_scroll_mapper_if #(.IDX_W(3), .ADDR_W(14), .SCROLL_W(7)) bus1 ();
  tile_scroll_mapper_if #(.IDX_W(3), .ADDR_W(14), .SCROLL_W(7)) bus5 ();

  tile_scroll_mapper #(.SCALE(1), .ROM_LATENCY(1)) u_dut1 (
    .vga_clk(clk), .reset_n(rst_n), .bus(bus1)
  );
  tile_scroll_mapper #(.SCALE(5), .ROM_LATENCY(2)) u_dut5 (
    .vga_clk(clk), .reset_n(rst_n), .bus(bus5)
  );

  assign bus1.DrawX = dx;  assign bus5.DrawX = dx;
  assign bus1.DrawY = dy;  assign bus5.DrawY = dy;
  assign bus1.blank = blk; assign bus5.blank = blk;
  assign bus1.scroll_x = scr; assign bus5.scroll_x = scr;
  assign bus1.rom_q = '0;
  assign bus1.pal_red = '0; assign bus1.pal_green = '0; assign bus1.pal_blue = '0;

  // Tile ROM model for the latency-2 instance: texel index = address mod 8.
  logic [2:0] rq1 = '0;
  logic [2:0] rq2 = '0;
  always @(posedge clk) begin
    rq1 <= bus5.rom_addr[2:0];
    rq2 <= rq1;
  end
  assign bus5.rom_q = rq2;

  logic [11:0] pal_tab [8] = '{12'hFFF, 12'h111, 12'h222, 12'hA52,
                               12'h123, 12'h456, 12'h789, 12'hBCD};
  logic [11:0] pal_sel;
  assign pal_sel = pal_tab[bus5.pal_index];
  assign bus5.pal_red   = pal_sel[11:8];
  assign bus5.pal_green = pal_sel[7:4];
  assign bus5.pal_blue  = pal_sel[3:0];

  logic [12:0] rgb5;
  assign rgb5 = {bus5.opaque, bus5.red, bus5.green, bus5.blue};

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one pixel sample and return at the following falling edge.
  task automatic px(input int x, input int y, input logic b);
    dx  = 10'(x);
    dy  = 10'(y);
    blk = b;
    @(negedge clk);
  endtask

  int          lat_x  [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  logic        lat_b  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int unsigned lat_e  [10] = '{0, 0, 0, 'h1A52, 'h1A52, 0, 'h1A52, 'h1A52, 'h1123, 'h1123};

  initial begin
    #1;
    check("reset_addr1", bus1.rom_addr, 0);
    check("reset_rgb5", rgb5, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-line sweep at SCALE=1, scroll 0.
    px(0, 0, 1);
    check("addr_0_0", bus1.rom_addr, 0);
    for (int x = 1; x <= 96; x++) begin
      px(x, 0, 1);
      if (x == 95) check("addr_95_0", bus1.rom_addr, 95);
      if (x == 96) check("addr_96_0_wrap", bus1.rom_addr, 0);
    end
    px(0, 1, 1);
    check("addr_0_1", bus1.rom_addr, 96);
    for (int y = 2; y <= 96; y++) begin
      px(0, y, 1);
      if (y == 95) check("addr_0_95", bus1.rom_addr, 9120);
      if (y == 96) check("addr_row_wrap", bus1.rom_addr, 0);
    end

    // Scroll latched at frame start only.
    scr = 7'd10;
    px(0, 0, 1);
    check("scroll10_0", bus1.rom_addr, 10);
    for (int x = 1; x <= 86; x++) begin
      px(x, 0, 1);
      if (x == 85) check("scroll10_85", bus1.rom_addr, 95);
      if (x == 86) check("scroll10_86", bus1.rom_addr, 0);
    end
    scr = 7'd50;
    px(0, 1, 1);
    check("scroll_midframe", bus1.rom_addr, 106);
    px(0, 0, 1);
    check("scroll50_frame", bus1.rom_addr, 50);
    scr = 7'd100;
    px(1, 0, 1);
    px(0, 0, 1);
    check("scroll100_wrap", bus1.rom_addr, 4);
    px(1, 0, 1);
    check("hold_1", bus1.rom_addr, 5);
    px(1, 0, 1);
    px(1, 0, 1);
    check("hold_3", bus1.rom_addr, 5);

    // SCALE=5 addressing.
    scr = 7'd0;
    px(0, 0, 1);
    check("s5_addr_0", bus5.rom_addr, 0);
    for (int x = 1; x <= 480; x++) begin
      px(x, 0, 1);
      if (x == 4)   check("s5_x4", bus5.rom_addr, 0);
      if (x == 5)   check("s5_x5", bus5.rom_addr, 1);
      if (x == 479) check("s5_x479", bus5.rom_addr, 95);
      if (x == 480) check("s5_x480_wrap", bus5.rom_addr, 0);
    end
    for (int y = 1; y <= 5; y++) begin
      px(0, y, 1);
      if (y == 4) check("s5_y4", bus5.rom_addr, 0);
      if (y == 5) check("s5_y5", bus5.rom_addr, 96);
    end

    // Latency and blank gating on the ROM_LATENCY=2 instance.
    px(1, 0, 0);
    px(1, 0, 0);
    px(1, 0, 0);
    scr = 7'd3;
    for (int k = 0; k < 10; k++) begin
      px(lat_x[k], 0, lat_b[k]);
      if (k == 0) check("lat_addr_x0", bus5.rom_addr, 3);
      if (k == 5) check("lat_addr_x5", bus5.rom_addr, 4);
      check($sformatf("lat_rgb_c%0d", k + 1), rgb5, lat_e[k]);
    end

    // Asynchronous reset mid-line, away from any rising edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb5", rgb5, 0);
    check("async_rst_addr1", bus1.rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    scr = 7'd7;
    px(0, 0, 0);
    check("resync_addr1", bus1.rom_addr, 7);
    check("resync_addr5", bus5.rom_addr, 7);
    check("resync_rgb5_blank", rgb5, 0);

    // Transparent texel with active video.
    px(1, 0, 0);
    scr = 7'd0;
    px(0, 0, 1);
    check("transp_addr", bus5.rom_addr, 0);
    px(0, 0, 1);
    px(0, 0, 1);
    px(0, 0, 1);
    check("transp_rgb", rgb5, 0);
    check("transp_pal_index", bus5.pal_index, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_scroll_mapper.md
Name: tile_scroll_mapper

Overview:
- Parametrised background tile mapper for the VGA pipeline. Maps (DrawX, DrawY) to a texel address of a TILE_W x TILE_H indexed tile image, scaled by integer factor SCALE, repeated across the screen, horizontally scrolled.
- Replaces per-pixel divide/multiply address generation with incremental counters. Adds a frame-latched scroll register, a ROM-latency-matched blank pipeline and a transparency flag for compositing with sprite layers.
- Tile ROM and palette are external to this block.

Parameters:
- TILE_W, 96: tile width in texels.
- TILE_H, 96: tile height in texels.
- SCALE, 5: screen pixels per texel, both axes; range 1..8.
- IDX_W, 3: palette index width.
- ROM_LATENCY, 1: tile ROM read latency in cycles; range 1..3.
- TRANSPARENT_IDX, 0: index treated as transparent.
- ADDR_W, clog2(TILE_W*TILE_H): ROM address width.

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- scroll_x  in  clog2(TILE_W)  horizontal scroll in texels.
- rom_addr  out  ADDR_W  registered tile ROM address.
- rom_q  in  IDX_W  tile ROM data, valid ROM_LATENCY cycles after rom_addr.
- pal_index  out  IDX_W  equals rom_q, drives the combinational palette.
- pal_red, pal_green, pal_blue  in  4 each  palette output.
- red, green, blue  out  4 each  registered pixel colour.
- opaque  out  1  registered: pixel valid and not transparent.

Behaviour:
- Reset (asynchronous, reset_n low):
  - rom_addr, red, green, blue and opaque all 0.
  - Counters tx, sx, ty, sy and the scroll shadow all 0.
  - Blank delay line all 0.
  - prev_x and prev_y set to all-ones, so the first (0,0) after reset counts as a frame start.
- Event detection, each cycle, comparing against prev_x/prev_y (registered copies of DrawX/DrawY):
  - frame_start: DrawX==0, DrawY==0, and previous position was not (0,0).
  - line_start: DrawX==0 and prev_x!=0.
  - x_step: DrawX!=prev_x and DrawX!=0.
  - y_step: DrawY!=prev_y and DrawY!=0.
- Scroll shadow:
  - Loaded only on frame_start.
  - Loaded value is scroll_x if scroll_x<TILE_W, else scroll_x-TILE_W.
  - Mid-frame changes to scroll_x have no effect until the next frame_start.
- Horizontal counters:
  - line_start: tx <= shadow; on frame_start the newly loaded value is used. sx <= 0.
  - x_step: if sx==SCALE-1 then sx <= 0 and tx <= (tx==TILE_W-1 ? 0 : tx+1); else sx <= sx+1.
- Vertical counters:
  - DrawY==0 with prev_y!=0: ty <= 0, sy <= 0.
  - y_step: same rule as horizontal, wrapping ty at TILE_H-1.
- Address:
  - rom_addr <= ty_next*TILE_W + tx_next, where *_next are the counter values being loaded this cycle.
  - Constant multiply; no divider anywhere in the block.
  - rom_addr is valid 1 cycle after the DrawX/DrawY sample.
- Pipeline latency:
  - Colour for the pixel sampled at cycle n appears on red/green/blue/opaque at cycle n+ROM_LATENCY+2.
  - blank goes through ROM_LATENCY+1 delay stages, then gates the output register.
- Output register:
  - Delayed blank 0: rgb <= 0, opaque <= 0.
  - Else if rom_q==TRANSPARENT_IDX: rgb <= 0, opaque <= 0.
  - Else: rgb <= pal_*, opaque <= 1.
- Edge cases:
  - Repeated identical DrawX (clock faster than pixel rate) must not advance the counters.
  - DrawX jumping back to 0 from any value is a line_start.
  - Reset mid-line: after release, the next (0,0) resynchronises the counters; output stays 0 while blank is 0.

Test Plan:
- Texel addressing, SCALE=1, scroll 0, blank=1, full line sweep:
  - DrawX 0/95/96/0 on DrawY=0 -> rom_addr 0/95/0.
  - DrawY=1, DrawX=0 -> rom_addr 96.
  - DrawY=96 -> row wraps to 0.
- Scroll, SCALE=1:
  - scroll_x=10 at frame start -> (0,0)=10, (85,0)=95, (86,0)=0.
  - scroll_x=50 written mid-frame -> lines keep starting at 10 until next frame, then 50.
  - scroll_x=100, TILE_W=96 -> latched as 4.
- Scaling, SCALE=5:
  - DrawX 0..4 -> tx 0; DrawX 5 -> tx 1; DrawX 479 -> tx 95.
  - DrawX 480 -> tx 0 (wrap).
  - DrawY 0..4 -> row 0; DrawY 5 -> address base 96.
- Latency and blank, ROM_LATENCY=2:
  - Sample pixel at cycle n -> colour at n+4.
  - blank 0 for one pixel -> exactly that output cycle is rgb 0, opaque 0.
- Transparency, TRANSPARENT_IDX=0:
  - rom_q=0 -> rgb 0, opaque 0.
  - rom_q=3 with pal=(A,5,2) -> rgb A/5/2, opaque 1.
- Reset and edge cases:
  - Assert reset_n low mid-line, asynchronous -> outputs 0 without a clock edge.
  - Release reset -> next (0,0) gives rom_addr=scroll value.
  - Hold DrawX constant for 3 cycles -> tx unchanged.
